ntt_bt_sched: RTL and testbench
===============================

Name: ntt_bt_sched

Overview:
- Sequencer for the butterfly (BT) unit in the 256-point ML-DSA NTT/INTT.
- Walks 8 stages × 128 butterflies per transform.
- Each cycle it issues coefficient-RAM read addresses, a zeta ROM index and a BT mode, then replays the write-back addresses through a delay line matched to RAM+BT latency.
- Sits between the top-level ML-DSA controller (start/done) and the coefficient RAM / BT datapath.

Parameters:
- RD_LAT, 1, coefficient RAM read latency in cycles.
- BT_LAT, 4, butterfly pipeline latency in cycles.
- D (localparam) = RD_LAT + BT_LAT, issue-to-write-back delay; must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = forward NTT (CT), 1 = inverse NTT (GS); latched at start.
- busy  out  1  transform in progress.
- done  out  1  one-cycle pulse after the final write-back.
- rd_en  out  1  read strobe for the butterfly pair.
- rd_addr_a  out  8  low coefficient address.
- rd_addr_b  out  8  high coefficient address (rd_addr_a + len).
- zeta_idx  out  8  zeta ROM index, valid with rd_en.
- bt_mode  out  1  latched mode, forwarded to the BT unit.
- stage  out  3  current stage s, 0..7.
- wr_en  out  1  rd_en delayed D cycles.
- wr_addr_a  out  8  rd_addr_a delayed D cycles.
- wr_addr_b  out  8  rd_addr_b delayed D cycles.

Behaviour:
- Reset (asynchronous, active-low): FSM = IDLE; counters, delay line and all outputs go to 0. Reset mid-transform aborts it with no done pulse; the next start after reset begins a fresh transform.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE: start=1 → ISSUE; c=0, s=0, mode latched into bt_mode.
  - ISSUE: rd_en=1; c increments each cycle. When c=127 → DRAIN with drain counter = D.
  - DRAIN: rd_en=0; counter decrements. When it reaches 1: if s<7, s++, c=0 → ISSUE; else → FIN.
  - FIN: done=1 for one cycle, busy=0 → IDLE.
- busy=1 in ISSUE and DRAIN; 0 in IDLE and FIN.
- The drain guarantees stage s+1 never reads a word before stage s has written it. First read of stage s+1 occurs the cycle after the last write of stage s.
- Address generation, butterfly index c in 0..127:
  - NTT: len = 128>>s, g = c>>(7-s).
  - INTT: len = 1<<s, g = c>>s.
  - Both modes: o = c & (len-1); rd_addr_a = 2·len·g + o; rd_addr_b = rd_addr_a + len.
  - zeta_idx: NTT = (1<<s) + g; INTT = (256>>s) − 1 − g. All arithmetic is 8-bit unsigned, no overflow by construction.
- Timing, with start high at cycle T:
  - Stage s issues rd_en on cycles T+1+s·(128+D) through T+128+s·(128+D).
  - wr_en/wr_addr are exactly the rd_en/rd_addr values from D cycles earlier. The delay line is shift registers, not recomputed.
  - Final wr_en at T+8·(128+D); done at T+8·(128+D)+1. With defaults D=5: final write T+1064, done T+1065.
- start while busy: ignored, with no effect on state or latched mode. start on the same cycle as done (FIN): ignored; accepted only in IDLE.
- mode changes while busy: ignored.
- stage output holds s throughout ISSUE and DRAIN; 0 in IDLE.

Optional Feature:
- Macro: NTT_BT_SCHED_STALL_EN.
- Defined:
  - Adds input stall (1) and output bt_ce (1); bt_ce = ~stall, used as the BT pipeline clock enable.
  - While stall=1: FSM, c, drain counter and delay line hold; rd_en and wr_en are forced 0 that cycle.
  - The held entries resume on release. All timing figures extend by the number of stalled cycles.
- Undefined: no stall/bt_ce ports; behaviour exactly as above.

Test Plan:
- NTT addressing: mode=0, start → s=0: c=0 gives a=0, b=128, zeta=1; c=127 gives a=127, b=255, zeta=1. s=7: c=0 gives a=0, b=1, zeta=128; c=127 gives a=254, b=255, zeta=255.
- INTT addressing: mode=1 → s=0: c=0 gives a=0, b=1, zeta=255; c=127 gives zeta=128. s=7: c=5 gives a=5, b=133, zeta=1.
- Timing, defaults: start at T → first rd_en T+1; first wr_en T+6 with wr_addr_a=0; stage-1 first rd_en T+134; done single pulse at T+1065; busy low at T+1065; exactly 1024 rd_en and 1024 wr_en cycles.
- start pulses at T+10 and T+500 and mode toggled mid-run → no restart; bt_mode constant; done still at T+1065.
- reset asserted at T+300 → all outputs 0 immediately; no done pulse; new start completes a normal 1065-cycle transform.
- (STALL_EN) stall high for 3 cycles during stage 2 ISSUE → address sequence unchanged; no rd_en/wr_en during stall; done at T+1068.

Source files
------------

// File: rtl/ntt_bt_sched.sv
// ntt_bt_sched: butterfly sequencer for the 256-point ML-DSA NTT/INTT.
// Walks 8 stages x 128 butterflies. Each issue cycle it emits a read pair, a zeta
// index and the BT mode. Write-back addresses are replayed through a D-deep
// shift register (D = RD_LAT + BT_LAT).
// Optional macro NTT_BT_SCHED_STALL_EN adds a stall input and a bt_ce output.
module ntt_bt_sched #(
  parameter int RD_LAT = 1,
  parameter int BT_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
`ifdef NTT_BT_SCHED_STALL_EN
  input  logic       stall,
  output logic       bt_ce,
`endif
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [7:0] zeta_idx,
  output logic       bt_mode,
  output logic [2:0] stage,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);
  localparam int D  = RD_LAT + BT_LAT;
  localparam int CW = $clog2(D + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  logic [1:0]          r_state;
  logic [6:0]          r_c;
  logic [2:0]          r_s;
  logic                r_mode;
  logic [CW-1:0]       r_dcnt;
  logic [D-1:0]        r_vld_pipe;
  logic [D-1:0][7:0]   r_pa;
  logic [D-1:0][7:0]   r_pb;

  logic       w_hold;
  logic       w_issue;
  logic [2:0] w_l;
  logic [7:0] w_len;
  logic [7:0] w_g;
  logic [7:0] w_o;
  logic [7:0] w_a;
  logic [7:0] w_b;
  logic [8:0] w_z9;
  logic [7:0] w_zeta;

`ifdef NTT_BT_SCHED_STALL_EN
  assign w_hold = stall;
  assign bt_ce  = ~stall;
`else
  assign w_hold = 1'b0;
`endif

  assign w_issue = (r_state == ISSUE);

  // Address/zeta generation; w_l is log2(len) so every multiply becomes a shift.
  always_comb begin
    w_l    = r_mode ? r_s : (3'd7 - r_s);
    w_len  = 8'd1 << w_l;
    w_g    = {1'b0, r_c} >> w_l;
    w_o    = {1'b0, r_c} & (w_len - 8'd1);
    w_a    = (w_g << ({1'b0, w_l} + 4'd1)) | w_o;
    w_b    = w_a + w_len;
    // INTT base 256>>s wraps to 0 for s=0 in 8 bits, which still gives 255-g.
    w_z9   = (9'd256 >> r_s) - 9'd1 - {1'b0, w_g};
    w_zeta = r_mode ? w_z9[7:0] : ((8'd1 << r_s) + w_g);
  end

  assign busy      = (r_state == ISSUE) || (r_state == DRAIN);
  assign done      = (r_state == FIN) & ~w_hold;
  assign rd_en     = w_issue & ~w_hold;
  assign rd_addr_a = w_issue ? w_a : 8'd0;
  assign rd_addr_b = w_issue ? w_b : 8'd0;
  assign zeta_idx  = w_issue ? w_zeta : 8'd0;
  assign bt_mode   = r_mode;
  assign stage     = busy ? r_s : 3'd0;
  assign wr_en     = r_vld_pipe[D-1] & ~w_hold;
  assign wr_addr_a = r_pa[D-1];
  assign wr_addr_b = r_pb[D-1];

  // Sequencer FSM: issue 128 pairs, drain D cycles so the next stage sees written data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_c     <= '0;
      r_s     <= '0;
      r_mode  <= 1'b0;
      r_dcnt  <= '0;
    end else if (!w_hold) begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= ISSUE;
          r_c     <= '0;
          r_s     <= '0;
          r_mode  <= mode;
        end
        ISSUE: begin
          r_c <= r_c + 7'd1;
          if (r_c == 7'd127) begin
            r_state <= DRAIN;
            r_dcnt  <= CW'(D);
          end
        end
        DRAIN: begin
          if (r_dcnt == CW'(1)) begin
            if (r_s == 3'd7) begin
              r_state <= FIN;
            end else begin
              r_state <= ISSUE;
              r_s     <= r_s + 3'd1;
              r_c     <= '0;
            end
          end else begin
            r_dcnt <= r_dcnt - CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_s     <= '0;
        end
      endcase
    end
  end

  // Write-back delay line: exact copy of the issue strobe and addresses D cycles later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_pa       <= '0;
      r_pb       <= '0;
    end else if (!w_hold) begin
      r_vld_pipe[0] <= w_issue;
      r_pa[0]       <= rd_addr_a;
      r_pb[0]       <= rd_addr_b;
      for (int i = 1; i < D; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_pa[i]       <= r_pa[i-1];
        r_pb[i]       <= r_pb[i-1];
      end
    end
  end
endmodule

// File: tb/tb_ntt_bt_sched.sv
// Directed bench for ntt_bt_sched: vector tables at fixed cycle offsets from start,
// plus whole-transform sequences (spurious start/mode, mid-run reset, stall).
module tb_ntt_bt_sched;
  logic       clk = 1'b0;
  logic       reset, start, mode;
  logic       busy, done, rd_en, bt_mode, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, zeta_idx, wr_addr_a, wr_addr_b;
  logic [2:0] stage;
`ifdef NTT_BT_SCHED_STALL_EN
  logic       stall = 1'b0;
  logic       bt_ce;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ntt_bt_sched dut (
    .clk(clk), .reset(reset),
`ifdef NTT_BT_SCHED_STALL_EN
    .stall(stall), .bt_ce(bt_ce),
`endif
    .start(start), .mode(mode), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .zeta_idx(zeta_idx), .bt_mode(bt_mode), .stage(stage),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  typedef struct {
    int         off;
    logic       rd;
    logic [7:0] a, b, z;
    logic [2:0] st;
    logic       wr;
    logic [7:0] wa, wb;
    logic       bsy, dn;
  } vec_t;

  vec_t ntt_v[12];
  vec_t intt_v[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    chk({tag, ".rd_en"},  32'(rd_en),     32'(v.rd));
    chk({tag, ".a"},      32'(rd_addr_a), 32'(v.a));
    chk({tag, ".b"},      32'(rd_addr_b), 32'(v.b));
    chk({tag, ".zeta"},   32'(zeta_idx),  32'(v.z));
    chk({tag, ".stage"},  32'(stage),     32'(v.st));
    chk({tag, ".wr_en"},  32'(wr_en),     32'(v.wr));
    chk({tag, ".wr_a"},   32'(wr_addr_a), 32'(v.wa));
    chk({tag, ".wr_b"},   32'(wr_addr_b), 32'(v.wb));
    chk({tag, ".busy"},   32'(busy),      32'(v.bsy));
    chk({tag, ".done"},   32'(done),      32'(v.dn));
  endtask

  // Reference addressing written with division/modulo rather than shifts.
  task automatic model(input logic m, input int s, input int c, output int a, output int b, output int z);
    int len, g, o;
    len = m ? (1 << s) : (128 >> s);
    g = c / len;
    o = c % len;
    a = g * 2 * len + o;
    b = a + len;
    z = m ? (256 / (1 << s)) - 1 - g : (1 << s) + g;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},  32'(busy),      0);
    chk({tag, ".done"},  32'(done),      0);
    chk({tag, ".rd_en"}, 32'(rd_en),     0);
    chk({tag, ".a"},     32'(rd_addr_a), 0);
    chk({tag, ".b"},     32'(rd_addr_b), 0);
    chk({tag, ".zeta"},  32'(zeta_idx),  0);
    chk({tag, ".stage"}, 32'(stage),     0);
    chk({tag, ".wr_en"}, 32'(wr_en),     0);
    chk({tag, ".wr_a"},  32'(wr_addr_a), 0);
    chk({tag, ".bt_mode"}, 32'(bt_mode), 0);
  endtask

  // One transform. tbl: 0 none, 1 NTT vectors, 2 INTT vectors.
  task automatic run(input string tag, input logic m, input int tbl, input bit noise,
                     input int rst_at, input int st_from, input int st_len, input int exp_done);
    int rdn = 0, wrn = 0, dn = 0, doff = -1;
    int bad_seq = 0, bad_mode = 0, bad_stall = 0, bad_dly = 0;
    int ea, eb, ez;
    logic       h_en[0:1199];
    logic [7:0] h_a[0:1199];
    logic [7:0] h_b[0:1199];
    bit stalled;
    mode  = m;
    start = 1'b1;
    for (int k = 1; k <= 1075; k++) begin
      @(posedge clk); #1;
      start   = noise && (k == 10 || k == 500 || k == 1065);
      if (noise && k == 200) mode = ~m;
      stalled = (st_len > 0) && (k >= st_from) && (k < st_from + st_len);
`ifdef NTT_BT_SCHED_STALL_EN
      stall = stalled;
`endif
      if (k == rst_at) begin
        reset = 1'b0;
        #1;
        chk_zero({tag, ".rst"});
        @(posedge clk); #1;
        reset = 1'b1;
        break;
      end
      #1;
      if (rd_en === 1'b1) begin
        model(m, rdn / 128, rdn % 128, ea, eb, ez);
        if (rd_addr_a !== 8'(ea) || rd_addr_b !== 8'(eb) || zeta_idx !== 8'(ez) ||
            stage !== 3'(rdn / 128)) bad_seq++;
        rdn++;
      end
      if (wr_en === 1'b1) wrn++;
      if (done === 1'b1) begin
        dn++;
        doff = k;
      end
      if (stalled && (rd_en !== 1'b0 || wr_en !== 1'b0)) bad_stall++;
`ifdef NTT_BT_SCHED_STALL_EN
      if (bt_ce !== ~stall) bad_stall++;
`endif
      if (busy === 1'b1 && bt_mode !== m) bad_mode++;
      h_en[k] = rd_en;
      h_a[k]  = rd_addr_a;
      h_b[k]  = rd_addr_b;
      if (st_len == 0 && k > 5) begin
        if (wr_en !== h_en[k-5] || (h_en[k-5] && (wr_addr_a !== h_a[k-5] || wr_addr_b !== h_b[k-5])))
          bad_dly++;
      end
      if (noise && k == 1067) chk({tag, ".fin_start_ignored"}, 32'(busy), 0);
      if (tbl == 1) foreach (ntt_v[i]) if (ntt_v[i].off == k) chk_vec($sformatf("%s.t%0d", tag, k), ntt_v[i]);
      if (tbl == 2) foreach (intt_v[i]) if (intt_v[i].off == k) chk_vec($sformatf("%s.t%0d", tag, k), intt_v[i]);
    end
`ifdef NTT_BT_SCHED_STALL_EN
    stall = 1'b0;
`endif
    start = 1'b0;
    if (rst_at > 0) begin
      chk({tag, ".no_done_after_reset"}, 32'(dn), 0);
    end else begin
      chk({tag, ".rd_count"},   32'(rdn),      1024);
      chk({tag, ".wr_count"},   32'(wrn),      1024);
      chk({tag, ".done_count"}, 32'(dn),       1);
      chk({tag, ".done_cycle"}, 32'(doff),     32'(exp_done));
      chk({tag, ".addr_seq"},   32'(bad_seq),  0);
      chk({tag, ".bt_mode"},    32'(bad_mode), 0);
      chk({tag, ".stall"},      32'(bad_stall), 0);
      if (st_len == 0) chk({tag, ".wr_delay"}, 32'(bad_dly), 0);
    end
  endtask

  initial begin
    //           off   rd  a    b    z    st  wr  wa   wb   bsy dn
    ntt_v[0]  = '{1,    1, 0,   128, 1,   0,  0,  0,   0,   1,  0};
    ntt_v[1]  = '{6,    1, 5,   133, 1,   0,  1,  0,   128, 1,  0};
    ntt_v[2]  = '{128,  1, 127, 255, 1,   0,  1,  122, 250, 1,  0};
    ntt_v[3]  = '{129,  0, 0,   0,   0,   0,  1,  123, 251, 1,  0};
    ntt_v[4]  = '{133,  0, 0,   0,   0,   0,  1,  127, 255, 1,  0};
    ntt_v[5]  = '{134,  1, 0,   64,  2,   1,  0,  0,   0,   1,  0};
    ntt_v[6]  = '{304,  1, 69,  101, 5,   2,  1,  64,  96,  1,  0};
    ntt_v[7]  = '{932,  1, 0,   1,   128, 7,  0,  0,   0,   1,  0};
    ntt_v[8]  = '{1059, 1, 254, 255, 255, 7,  1,  244, 245, 1,  0};
    ntt_v[9]  = '{1064, 0, 0,   0,   0,   7,  1,  254, 255, 1,  0};
    ntt_v[10] = '{1065, 0, 0,   0,   0,   0,  0,  0,   0,   0,  1};
    ntt_v[11] = '{1066, 0, 0,   0,   0,   0,  0,  0,   0,   0,  0};
    intt_v[0] = '{1,    1, 0,   1,   255, 0,  0,  0,   0,   1,  0};
    intt_v[1] = '{128,  1, 254, 255, 128, 0,  1,  244, 245, 1,  0};
    intt_v[2] = '{137,  1, 5,   7,   126, 1,  0,  0,   0,   1,  0};
    intt_v[3] = '{937,  1, 5,   133, 1,   7,  1,  0,   128, 1,  0};
    intt_v[4] = '{1065, 0, 0,   0,   0,   0,  0,  0,   0,   0,  1};

    reset = 1'b0;
    start = 1'b0;
    mode  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b1;
    @(posedge clk); #2;

    run("ntt",       1'b0, 1, 1'b0, 0,   0,   0, 1065);
    run("intt",      1'b1, 2, 1'b0, 0,   0,   0, 1065);
    run("noise",     1'b1, 0, 1'b1, 0,   0,   0, 1065);
    run("abort",     1'b1, 0, 1'b0, 300, 0,   0, 0);
    run("after_rst", 1'b0, 1, 1'b0, 0,   0,   0, 1065);
`ifdef NTT_BT_SCHED_STALL_EN
    run("stall",     1'b0, 0, 1'b0, 0,   270, 3, 1068);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
